// File: rtl/ob_cmd_arb.sv
// ob_cmd_arb: round-robin arbiter granting N_CLIENTS command ports onto the single
// ob command interface, with an in-order tag FIFO steering ob responses back to their issuer.

package ob_pkg;
  localparam int unsigned CMD_W = 32;
  localparam int unsigned RSP_W = 32;
  typedef logic [CMD_W-1:0] cmd_t;
  typedef logic [RSP_W-1:0] rsp_t;
endpackage

module ob_cmd_arb #(
  parameter int unsigned N_CLIENTS   = 4,
  parameter int unsigned OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_CLIENTS-1:0]                 cl_cmd_vld,
  input  logic [N_CLIENTS*ob_pkg::CMD_W-1:0]   cl_cmd,
  output logic [N_CLIENTS-1:0]                 cl_cmd_rdy,
  output logic [N_CLIENTS-1:0]                 cl_rsp_vld,
  output logic [ob_pkg::RSP_W-1:0]             cl_rsp,
  input  logic [N_CLIENTS-1:0]                 cl_rsp_accept,
  output logic                                 ob_cmd_vld_r,
  output logic [ob_pkg::CMD_W-1:0]             ob_cmd_r,
  input  logic                                 ob_cmd_full_r,
  input  logic                                 ob_rsp_vld,
  input  logic [ob_pkg::RSP_W-1:0]             ob_rsp,
  output logic                                 ob_rsp_accept,
  output logic [$clog2(OUTSTANDING+1)-1:0]     outstanding_r,
  output logic                                 err_orphan_r
);

  localparam int unsigned CMD_W = ob_pkg::CMD_W;
  localparam int unsigned IDX_W = $clog2(N_CLIENTS);
  localparam int unsigned PTR_W = $clog2(OUTSTANDING);
  localparam int unsigned CNT_W = $clog2(OUTSTANDING+1);

  logic             ob_cmd_vld_q, ob_cmd_vld_d;
  logic [CMD_W-1:0] ob_cmd_q, ob_cmd_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             err_orphan_q, err_orphan_d;
  logic [IDX_W-1:0] tag_q [OUTSTANDING];
  logic [IDX_W-1:0] tag_d [OUTSTANDING];

  logic             issue_ok;
  logic             found;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] gnt_idx;
  logic             push;
  logic             pop;
  logic             has_out;
  logic             orphan;
  logic [IDX_W-1:0] head;

  // Grants are also held off while rst is low, since no flop can capture a consumed command then.
  assign issue_ok = rst & ~ob_cmd_full_r & (outstanding_q < CNT_W'(OUTSTANDING));

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_CLIENTS)) begin
        cand = cand - (IDX_W+1)'(N_CLIENTS);
      end
      if (!found && cl_cmd_vld[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign push = found & issue_ok;

  always_comb begin
    cl_cmd_rdy = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      cl_cmd_rdy[i] = push & (gnt_idx == IDX_W'(i));
    end
  end

  assign head    = tag_q[rd_ptr_q];
  assign has_out = (outstanding_q != '0);
  assign orphan  = ob_rsp_vld & ~has_out;

  always_comb begin
    cl_rsp_vld = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      cl_rsp_vld[i] = ob_rsp_vld & has_out & (head == IDX_W'(i));
    end
  end

  assign cl_rsp        = ob_rsp;
  // With nothing outstanding, ob is always accepted so a stray response drains.
  assign ob_rsp_accept = has_out ? cl_rsp_accept[head] : 1'b1;
  assign pop           = ob_rsp_vld & has_out & cl_rsp_accept[head];

  always_comb begin
    ob_cmd_vld_d  = push;
    ob_cmd_d      = ob_cmd_q;
    rr_ptr_d      = rr_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q;
    err_orphan_d  = err_orphan_q | orphan;
    tag_d         = tag_q;

    if (push) begin
      ob_cmd_d       = cl_cmd[gnt_idx*CMD_W +: CMD_W];
      tag_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d       = wr_ptr_q + PTR_W'(1);
      rr_ptr_d       = (gnt_idx == IDX_W'(N_CLIENTS-1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob_cmd_vld_q  <= 1'b0;
      ob_cmd_q      <= '0;
      rr_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      err_orphan_q  <= 1'b0;
      tag_q         <= '{default: '0};
    end else begin
      ob_cmd_vld_q  <= ob_cmd_vld_d;
      ob_cmd_q      <= ob_cmd_d;
      rr_ptr_q      <= rr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      err_orphan_q  <= err_orphan_d;
      tag_q         <= tag_d;
    end
  end

  assign ob_cmd_vld_r  = ob_cmd_vld_q;
  assign ob_cmd_r      = ob_cmd_q;
  assign outstanding_r = outstanding_q;
  assign err_orphan_r  = err_orphan_q;

endmodule

// File: tb/tb_ob_cmd_arb.sv
// Directed bench for ob_cmd_arb: round-robin order, pointer persistence, ob stall,
// outstanding limit, orphan responses and asynchronous reset mid-flight.

module tb_ob_cmd_arb;

  localparam int N  = 4;
  localparam int CW = ob_pkg::CMD_W;
  localparam int RW = ob_pkg::RSP_W;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  cl_cmd_vld;
  logic [N*CW-1:0] cl_cmd;
  logic [N-1:0]  cl_cmd_rdy;
  logic [N-1:0]  cl_rsp_vld;
  logic [RW-1:0] cl_rsp;
  logic [N-1:0]  cl_rsp_accept;
  logic          ob_cmd_vld_r;
  logic [CW-1:0] ob_cmd_r;
  logic          ob_cmd_full_r;
  logic          ob_rsp_vld;
  logic [RW-1:0] ob_rsp;
  logic          ob_rsp_accept;
  logic [3:0]    outstanding_r;
  logic          err_orphan_r;

  int errors = 0;
  int checks = 0;
  int seq [N];

  ob_cmd_arb #(.N_CLIENTS(4), .OUTSTANDING(8)) dut (
    .clk(clk), .rst(rst),
    .cl_cmd_vld(cl_cmd_vld), .cl_cmd(cl_cmd), .cl_cmd_rdy(cl_cmd_rdy),
    .cl_rsp_vld(cl_rsp_vld), .cl_rsp(cl_rsp), .cl_rsp_accept(cl_rsp_accept),
    .ob_cmd_vld_r(ob_cmd_vld_r), .ob_cmd_r(ob_cmd_r), .ob_cmd_full_r(ob_cmd_full_r),
    .ob_rsp_vld(ob_rsp_vld), .ob_rsp(ob_rsp), .ob_rsp_accept(ob_rsp_accept),
    .outstanding_r(outstanding_r), .err_orphan_r(err_orphan_r)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cmd_of(input int c, input int s);
    return 32'h1000_0000 * 32'(c + 1) + 32'(s);
  endfunction

  task automatic load_cmds();
    for (int c = 0; c < N; c++) cl_cmd[c*CW +: CW] = cmd_of(c, seq[c]);
  endtask

  task automatic test_reset();
    rst = 1'b0; cl_cmd_vld = '0; cl_rsp_accept = '0; ob_cmd_full_r = 1'b0;
    ob_rsp_vld = 1'b0; ob_rsp = '0;
    for (int c = 0; c < N; c++) seq[c] = 0;
    load_cmds();
    @(posedge clk); #1;
    checks++; if (ob_cmd_vld_r !== 1'b0) begin errors++; $display("FAIL reset_cmd_vld: got %b want 0", ob_cmd_vld_r); end
    checks++; if (ob_cmd_r !== '0) begin errors++; $display("FAIL reset_cmd: got %h want 0", ob_cmd_r); end
    checks++; if (outstanding_r !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_r); end
    checks++; if (err_orphan_r !== 1'b0) begin errors++; $display("FAIL reset_orphan: got %b want 0", err_orphan_r); end
    checks++; if (cl_cmd_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy: got %b want 0000", cl_cmd_rdy); end
    checks++; if (cl_rsp_vld !== 4'b0000) begin errors++; $display("FAIL reset_rsp_vld: got %b want 0000", cl_rsp_vld); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [CW-1:0] exp_cmd;
    logic [3:0]    exp_v;
    exp_cmd = '0;
    cl_rsp_accept = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cl_cmd_vld = (k < 8) ? 4'b1111 : 4'b0000;
      load_cmds();
      ob_rsp_vld = (k >= 1 && k <= 8);
      ob_rsp     = 32'hE000_0000 + 32'(k);
      #1;
      exp_v = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      checks++; if (cl_cmd_rdy !== exp_v) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, cl_cmd_rdy, exp_v); end
      if (k >= 1 && k <= 8) begin
        checks++; if (ob_cmd_vld_r !== 1'b1) begin errors++; $display("FAIL rr_cmd_vld[%0d]: got %b want 1", k, ob_cmd_vld_r); end
        checks++; if (ob_cmd_r !== exp_cmd) begin errors++; $display("FAIL rr_cmd[%0d]: got %h want %h", k, ob_cmd_r, exp_cmd); end
        exp_v = 4'b0001 << ((k - 1) % 4);
        checks++; if (cl_rsp_vld !== exp_v) begin errors++; $display("FAIL rr_rsp_vld[%0d]: got %b want %b", k, cl_rsp_vld, exp_v); end
        checks++; if (cl_rsp !== 32'hE000_0000 + 32'(k)) begin errors++; $display("FAIL rr_rsp[%0d]: got %h want %h", k, cl_rsp, 32'hE000_0000 + 32'(k)); end
        checks++; if (ob_rsp_accept !== 1'b1) begin errors++; $display("FAIL rr_accept[%0d]: got %b want 1", k, ob_rsp_accept); end
        checks++; if (outstanding_r !== 4'd1) begin errors++; $display("FAIL rr_outstanding[%0d]: got %0d want 1", k, outstanding_r); end
      end
      if (k == 9) begin
        checks++; if (outstanding_r !== 4'd0) begin errors++; $display("FAIL rr_drained: got %0d want 0", outstanding_r); end
        checks++; if (ob_cmd_vld_r !== 1'b0) begin errors++; $display("FAIL rr_idle_vld: got %b want 0", ob_cmd_vld_r); end
      end
      if (k < 8) begin
        exp_cmd = cmd_of(k % 4, seq[k % 4]);
        seq[k % 4]++;
      end
    end
  endtask

  task automatic test_ob_full();
    logic [CW-1:0] exp_cmd;
    @(negedge clk); ob_rsp_vld = 1'b0; cl_rsp_accept = '0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      ob_cmd_full_r = 1'b1; cl_cmd_vld = 4'b0101; load_cmds(); #1;
      checks++; if (cl_cmd_rdy !== 4'b0000) begin errors++; $display("FAIL full_rdy[%0d]: got %b want 0000", k, cl_cmd_rdy); end
      checks++; if (ob_cmd_vld_r !== 1'b0) begin errors++; $display("FAIL full_cmd_vld[%0d]: got %b want 0", k, ob_cmd_vld_r); end
    end
    @(negedge clk); ob_cmd_full_r = 1'b0; #1;
    checks++; if (cl_cmd_rdy !== 4'b0001) begin errors++; $display("FAIL full_release_rdy: got %b want 0001", cl_cmd_rdy); end
    exp_cmd = cmd_of(0, seq[0]); seq[0]++;
    @(negedge clk); cl_cmd_vld = 4'b0100; load_cmds(); #1;
    checks++; if (cl_cmd_rdy !== 4'b0100) begin errors++; $display("FAIL full_second_rdy: got %b want 0100", cl_cmd_rdy); end
    checks++; if (ob_cmd_r !== exp_cmd) begin errors++; $display("FAIL full_cmd: got %h want %h", ob_cmd_r, exp_cmd); end
    seq[2]++;
    @(negedge clk); cl_cmd_vld = '0; ob_rsp_vld = 1'b1; cl_rsp_accept = 4'b0001; #1;
    checks++; if (cl_rsp_vld !== 4'b0001) begin errors++; $display("FAIL full_rsp0: got %b want 0001", cl_rsp_vld); end
    checks++; if (outstanding_r !== 4'd2) begin errors++; $display("FAIL full_outstanding: got %0d want 2", outstanding_r); end
    @(negedge clk); cl_rsp_accept = 4'b0100; #1;
    checks++; if (cl_rsp_vld !== 4'b0100) begin errors++; $display("FAIL full_rsp2: got %b want 0100", cl_rsp_vld); end
    @(negedge clk); ob_rsp_vld = 1'b0; cl_rsp_accept = '0; #1;
    checks++; if (outstanding_r !== 4'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", outstanding_r); end
  endtask

  task automatic test_ptr_persist();
    logic [3:0] vld_tab [4] = '{4'b0010, 4'b1001, 4'b0001, 4'b0011};
    logic [3:0] gnt_tab [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] rsp_tab [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); cl_cmd_vld = vld_tab[k]; #1;
      checks++; if (cl_cmd_rdy !== gnt_tab[k]) begin errors++; $display("FAIL ptr_grant[%0d]: got %b want %b", k, cl_cmd_rdy, gnt_tab[k]); end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); cl_cmd_vld = '0; ob_rsp_vld = 1'b1; cl_rsp_accept = 4'b1111; #1;
      if (k == 0) begin
        checks++; if (outstanding_r !== 4'd4) begin errors++; $display("FAIL ptr_outstanding: got %0d want 4", outstanding_r); end
      end
      checks++; if (cl_rsp_vld !== rsp_tab[k]) begin errors++; $display("FAIL ptr_rsp[%0d]: got %b want %b", k, cl_rsp_vld, rsp_tab[k]); end
    end
    @(negedge clk); ob_rsp_vld = 1'b0; cl_rsp_accept = '0; #1;
    checks++; if (outstanding_r !== 4'd0) begin errors++; $display("FAIL ptr_drained: got %0d want 0", outstanding_r); end
  endtask

  task automatic test_outstanding_limit();
    int         grants;
    logic [3:0] exp_v;
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); cl_cmd_vld = 4'b0010; #1;
      if (cl_cmd_rdy === 4'b0010) grants++;
      exp_v = (k < 8) ? 4'b0010 : 4'b0000;
      checks++; if (cl_cmd_rdy !== exp_v) begin errors++; $display("FAIL lim_grant[%0d]: got %b want %b", k, cl_cmd_rdy, exp_v); end
    end
    checks++; if (grants != 8) begin errors++; $display("FAIL lim_count: got %0d want 8", grants); end
    checks++; if (outstanding_r !== 4'd8) begin errors++; $display("FAIL lim_full: got %0d want 8", outstanding_r); end
    @(negedge clk); ob_rsp_vld = 1'b1; cl_rsp_accept = 4'b0000; #1;
    checks++; if (cl_rsp_vld !== 4'b0010) begin errors++; $display("FAIL lim_rsp_vld: got %b want 0010", cl_rsp_vld); end
    checks++; if (ob_rsp_accept !== 1'b0) begin errors++; $display("FAIL lim_hold_accept: got %b want 0", ob_rsp_accept); end
    @(negedge clk); cl_rsp_accept = 4'b0010; #1;
    checks++; if (ob_rsp_accept !== 1'b1) begin errors++; $display("FAIL lim_pop_accept: got %b want 1", ob_rsp_accept); end
    checks++; if (cl_cmd_rdy !== 4'b0000) begin errors++; $display("FAIL lim_no_bypass: got %b want 0000", cl_cmd_rdy); end
    checks++; if (outstanding_r !== 4'd8) begin errors++; $display("FAIL lim_held: got %0d want 8", outstanding_r); end
    @(negedge clk); ob_rsp_vld = 1'b0; cl_rsp_accept = '0; #1;
    checks++; if (outstanding_r !== 4'd7) begin errors++; $display("FAIL lim_after_pop: got %0d want 7", outstanding_r); end
    checks++; if (cl_cmd_rdy !== 4'b0010) begin errors++; $display("FAIL lim_ninth: got %b want 0010", cl_cmd_rdy); end
    @(negedge clk); cl_cmd_vld = '0; #1;
    checks++; if (outstanding_r !== 4'd8) begin errors++; $display("FAIL lim_refill: got %0d want 8", outstanding_r); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); ob_rsp_vld = 1'b1; cl_rsp_accept = 4'b1111; #1;
      checks++; if (cl_rsp_vld !== 4'b0010) begin errors++; $display("FAIL lim_drain[%0d]: got %b want 0010", k, cl_rsp_vld); end
    end
    @(negedge clk); ob_rsp_vld = 1'b0; cl_rsp_accept = '0; #1;
    checks++; if (outstanding_r !== 4'd0) begin errors++; $display("FAIL lim_drained: got %0d want 0", outstanding_r); end
  endtask

  task automatic test_orphan();
    @(negedge clk); #1;
    checks++; if (err_orphan_r !== 1'b0) begin errors++; $display("FAIL orphan_pre: got %b want 0", err_orphan_r); end
    @(negedge clk); ob_rsp_vld = 1'b1; cl_rsp_accept = '0; #1;
    checks++; if (ob_rsp_accept !== 1'b1) begin errors++; $display("FAIL orphan_accept: got %b want 1", ob_rsp_accept); end
    checks++; if (cl_rsp_vld !== 4'b0000) begin errors++; $display("FAIL orphan_rsp_vld: got %b want 0000", cl_rsp_vld); end
    @(negedge clk); ob_rsp_vld = 1'b0; #1;
    checks++; if (err_orphan_r !== 1'b1) begin errors++; $display("FAIL orphan_set: got %b want 1", err_orphan_r); end
    checks++; if (outstanding_r !== 4'd0) begin errors++; $display("FAIL orphan_outstanding: got %0d want 0", outstanding_r); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err_orphan_r !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", err_orphan_r); end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); cl_cmd_vld = 4'b0100;
    end
    @(negedge clk); cl_cmd_vld = '0; #1;
    checks++; if (outstanding_r !== 4'd5) begin errors++; $display("FAIL mid_outstanding: got %0d want 5", outstanding_r); end
    checks++; if (ob_cmd_vld_r !== 1'b1) begin errors++; $display("FAIL mid_cmd_vld: got %b want 1", ob_cmd_vld_r); end
    #2 rst = 1'b0;
    #1;
    checks++; if (outstanding_r !== 4'd0) begin errors++; $display("FAIL mid_rst_outstanding: got %0d want 0", outstanding_r); end
    checks++; if (ob_cmd_vld_r !== 1'b0) begin errors++; $display("FAIL mid_rst_cmd_vld: got %b want 0", ob_cmd_vld_r); end
    checks++; if (ob_cmd_r !== '0) begin errors++; $display("FAIL mid_rst_cmd: got %h want 0", ob_cmd_r); end
    checks++; if (err_orphan_r !== 1'b0) begin errors++; $display("FAIL mid_rst_orphan: got %b want 0", err_orphan_r); end
    @(negedge clk); rst = 1'b1; cl_cmd_vld = 4'b1111; #1;
    checks++; if (cl_cmd_rdy !== 4'b0001) begin errors++; $display("FAIL mid_rst_ptr: got %b want 0001", cl_cmd_rdy); end
    @(negedge clk); cl_cmd_vld = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_ob_full();
    test_ptr_persist();
    test_outstanding_limit();
    test_orphan();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
